// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. A two-flop synchronizer feeds a mid-bit
//                sampling state machine; each good byte is presented on
//                rx_data with a one-cycle rx_valid strobe, and a low stop bit
//                raises a one-cycle rx_frame_err strobe. After a framing error
//                the receiver waits for the line to return high so that a
//                held-low (break) line cannot restart reception.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    // Counter width follows the bit period; guard the degenerate width.
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: half a bit from the start edge lands mid start bit,
    // a full bit from there lands mid data/stop bit.
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;

    // Two-flop synchronizer for the asynchronous serial input; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive state machine with registered data, strobes and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_sync) begin
                        r_state <= S_START;
                        rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (!r_rx_sync) begin
                            // Still low at mid start bit: a genuine start.
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Line went back high: treat as a glitch.
                            r_state <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        // LSB arrives first, so shift in from the top.
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_rx_sync) begin
                            // Returning to idle at mid stop bit leaves half a
                            // bit to catch a start bit that follows directly.
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= S_IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            r_state      <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_BREAK: begin
                    // Hold off until the line is released to mark.
                    r_cnt <= '0;
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx. Stimulus pushes the expected
//                strobe (kind, data, timing window) for each frame it sends;
//                a monitor pops and compares on every rx_valid/rx_frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 868;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loopback = 1'b0;
    logic       tx_line = 1'b1;
    logic       tx_ready = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    assign rx_pin = loopback ? tx_line : rx_drv;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_pin),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] last_good = 8'h00;
    int         last_valid_cyc = -100000;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Expected strobe for a frame whose start bit is first sampled at edge t0.
    task automatic expect_frame(input bit is_err, input logic [7:0] data, input int t0);
        exp_t e;
        e.is_err = is_err;
        e.data   = is_err ? last_good : data;
        e.lo     = t0 + LAT - 2;
        e.hi     = t0 + LAT + 2;
        sb.push_back(e);
        if (!is_err) last_good = data;
    endtask

    // Called just after a clock edge; holds the level for one bit time.
    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        expect_frame(!stop, b, cyc + 1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("pending_strobes", sb.size(), 0);
        sb.delete();
    endtask

    // Bit-serial transmitter standing in for uart.tx on the loopback path.
    always begin
        @(posedge clk);
        if (tx_en) begin
            #1;
            tx_ready = 1'b0;
            expect_frame(1'b0, tx_byte, cyc + 1);
            tx_line = 1'b0;
            repeat (CPB) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                tx_line = tx_byte[i];
                repeat (CPB) @(posedge clk);
                #1;
            end
            tx_line = 1'b1;
            repeat (CPB) @(posedge clk);
            #1;
            tx_ready = 1'b1;
        end
    end

    // Monitor: every strobe must match the head of the scoreboard.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1 || rx_frame_err === 1'b1) begin
            if (rx_valid === 1'b1) last_valid_cyc = cyc;
            check("strobe_exclusive", int'(rx_valid & rx_frame_err), 0);
            if (prev_strobe) begin
                n_total++;
                $display("FAIL strobe_consecutive: strobe at cycle %0d follows a strobe, expected a gap", cyc);
            end
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%02h, expected none",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                e = sb.pop_front();
                check("strobe_kind_err", int'(rx_frame_err), int'(e.is_err));
                check("rx_data", int'(rx_data), int'(e.data));
                check_win("strobe_time", cyc, e.lo, e.hi);
            end
            prev_strobe = 1'b1;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  ready_cyc;
        int  n;
        bit  seen_busy;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_frame_err", int'(rx_frame_err), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single 'H' frame
        send_frame(8'h48, 1'b1);
        drain(4 * CPB);
        check("t1_busy_after", int'(rx_busy), 0);
        check("t1_rx_data_held", int'(rx_data), 8'h48);

        // Short low glitch, then idle
        seen_busy = 1'b0;
        rx_drv = 1'b0;
        repeat (CPB / 4) begin
            @(posedge clk);
            #1;
            if (rx_busy) seen_busy = 1'b1;
        end
        rx_drv = 1'b1;
        repeat (CPB) begin
            @(posedge clk);
            #1;
            if (rx_busy) seen_busy = 1'b1;
        end
        check("t3_busy_seen", int'(seen_busy), 1);
        check("t3_busy_after", int'(rx_busy), 0);
        check("t3_rx_data", int'(rx_data), 8'h48);

        // Framing error followed by a 20-bit break, then a good byte
        send_frame(8'h55, 1'b0);
        repeat (10 * CPB) @(posedge clk);
        #1;
        check("t4_busy_in_break", int'(rx_busy), 1);
        check("t4_rx_data_kept", int'(rx_data), 8'h48);
        repeat (10 * CPB) @(posedge clk);
        #1;
        drain(1);
        rx_drv = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        check("t4_busy_released", int'(rx_busy), 0);
        send_frame(8'hA5, 1'b1);
        drain(4 * CPB);
        check("t4_rx_data_a5", int'(rx_data), 8'hA5);

        // Back-to-back frames with no idle gap
        send_frame(8'h52, 1'b1);
        send_frame(8'h00, 1'b1);
        drain(4 * CPB);
        check("t2_rx_data_last", int'(rx_data), 8'h00);

        // Reset after the 4th data bit of a frame
        expect_frame(1'b0, 8'h00, 0);
        sb.delete();
        rx_drv = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rst = 1'b1;
        rx_drv = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 8'h00;
        check("t5_rx_data_reset", int'(rx_data), 0);
        check("t5_rx_valid_reset", int'(rx_valid), 0);
        check("t5_rx_frame_err_reset", int'(rx_frame_err), 0);
        check("t5_rx_busy_reset", int'(rx_busy), 0);
        repeat (CPB) @(posedge clk);
        #1;
        check("t5_still_idle", int'(rx_busy), 0);
        send_frame(8'hFF, 1'b1);
        drain(4 * CPB);
        check("t5_rx_data_ff", int'(rx_data), 8'hFF);

        // Loopback from a bit-serial transmitter sending 'R'
        loopback = 1'b1;
        @(posedge clk);
        #1;
        tx_byte = 8'h52;
        tx_en = 1'b1;
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        n = 0;
        while (tx_ready !== 1'b1 && n < 12 * CPB) begin
            @(posedge clk);
            #1;
            n++;
        end
        ready_cyc = cyc;
        check("t6_tx_done", int'(tx_ready), 1);
        drain(2 * CPB);
        check_win("t6_tx_ready_vs_valid", ready_cyc, 0, last_valid_cyc + CPB);
        check("t6_rx_data", int'(rx_data), 8'h52);
        loopback = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It consumes the serial line driven by the `uart` transmitter (`tx` pin) and presents received bytes on a single-cycle valid strobe.
- It sits at the board RX pin, or on the internal loopback from `uart.tx`, and feeds byte consumers in the same `clk` domain.
- It uses the same bit-time convention as the transmitter, so one parameter value pairs both ends.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200). Legal range ≥ 4; values are treated as-is, with no rounding.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  last correctly received byte; held until the next good byte.
- rx_valid  out  1  one-cycle pulse, rx_data updated this cycle.
- rx_frame_err  out  1  one-cycle pulse, stop bit sampled low.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - Both synchronizer flops = 1; state=IDLE; bit counter=0; cycle counter=0.
  - Reset wins over every other event, including mid-frame. A partial byte is discarded and no strobe is emitted.
- Input sync: 2-flop synchronizer rx → rx_s. All decisions use rx_s only.
- Cycle counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- FSM:
  - IDLE: when rx_s=0, go to START with counter=0.
  - START: count to CLKS_PER_BIT/2 − 1 (integer divide).
    - At the terminal count, if rx_s=0, go to DATA (counter=0, bit_idx=0).
    - Otherwise it was a glitch: return to IDLE with no strobe.
  - DATA: count to CLKS_PER_BIT − 1.
    - At the terminal count, sample rx_s LSB-first: shift_reg <= {rx_s, shift_reg[7:1]}.
    - After bit_idx=7 is sampled, go to STOP; otherwise bit_idx++.
  - STOP: count to CLKS_PER_BIT − 1, then sample rx_s.
    - If 1: rx_data <= shift_reg, rx_valid=1 for exactly one cycle, go to IDLE.
    - If 0: rx_frame_err=1 for exactly one cycle, rx_data unchanged, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line (break) from restarting reception.
- rx_valid and rx_frame_err are mutually exclusive and never high on consecutive cycles.
- Latency:
  - Let t0 = the first clk edge at which rx is low.
  - rx_valid is asserted on edge t0 + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (±1). Bench tolerance is ±2 cycles.
- Back-to-back frames:
  - Returning to IDLE at the stop-bit midpoint leaves half a bit time to detect the next start edge.
  - A start bit that immediately follows a stop bit must be received with no lost byte.
- Baud mismatch up to ±2 % must still decode correctly (mid-bit sampling).
- No internal buffering. The consumer must take rx_data on the cycle rx_valid is high, or before the next good byte overwrites it.

Test Plan:
1. Drive a 'H' (0x48) frame at CLKS_PER_BIT=868 → exactly one rx_valid pulse; rx_data=0x48 inside the latency window; rx_frame_err stays 0; rx_busy falls to 0 after the pulse.
2. Send 0x52 then 0x00 back-to-back, with the next start bit immediately after the stop bit → two rx_valid pulses about 10·CLKS_PER_BIT apart; rx_data reads 0x52 then 0x00.
3. Pulse rx low for CLKS_PER_BIT/4 cycles, then hold high → rx_busy pulses high then returns to 0; no rx_valid; no rx_frame_err; rx_data unchanged.
4. Send 0x55 with the stop bit forced low, then hold rx low for 20 bit times, then release high and send 0xA5:
   - One rx_frame_err pulse and no rx_valid for 0x55.
   - rx_data keeps its prior value and no spurious frames appear during the low hold.
   - 0xA5 is then received correctly.
5. Assert rst for one cycle after the 4th data bit of a frame → the next cycle shows all outputs at reset values and no strobe for that frame; a following 0xFF frame is received correctly.
6. Loopback: uart.tx → uart_rx.rx at CLKS_PER_BIT=868, with the transmitter sending 'R' via a one-cycle tx_en → rx_valid with rx_data=0x52; the transmitter's tx_ready returns high before or at rx_valid + CLKS_PER_BIT.
